// File: rtl/ddr4_cmd_scheduler.sv
// ddr4_cmd_scheduler: single-requester DDR4 command sequencer with open-page bank table.
// Ports: clk, reset_n, req_* handshake in, done/done_we out, DIMM pins cs_n/act_n/A/bg/ba out.
module ddr4_cmd_scheduler #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRP       = 4,
    parameter int TRCD      = 4,
    parameter int TRAS      = 10,
    parameter int TCCD      = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 done,
    output logic                 done_we,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba
);

    localparam int BKW   = BGWIDTH + BAWIDTH;
    localparam int NBANK = 1 << BKW;
    localparam int RASW  = $clog2(TRAS + 1);
    localparam int CCDW  = $clog2(TCCD + 1);
    localparam int WMAX  = (TRP > TRCD) ? TRP : TRCD;
    localparam int WW    = (WMAX > 1) ? $clog2(WMAX) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DECIDE   = 3'd1;
    localparam logic [2:0] S_PRE      = 3'd2;
    localparam logic [2:0] S_WAIT_RP  = 3'd3;
    localparam logic [2:0] S_WAIT_RCD = 3'd4;
    localparam logic [2:0] S_COL      = 3'd5;

    // A16 = ras_n, A15 = cas_n, A14 = we_n
    localparam logic [ADDRWIDTH-1:0] BIT_RAS = {1'b1, {(ADDRWIDTH-1){1'b0}}};
    localparam logic [ADDRWIDTH-1:0] BIT_CAS = BIT_RAS >> 1;
    localparam logic [ADDRWIDTH-1:0] BIT_WE  = BIT_RAS >> 2;

    logic [2:0]           state;
    logic [2:0]           state_n;

    logic                 r_we;
    logic [BKW-1:0]       r_bank;
    logic [ADDRWIDTH-1:0] r_row;
    logic [COLWIDTH-1:0]  r_col;

    logic [NBANK-1:0]     bank_open;
    logic [ADDRWIDTH-1:0] bank_row [NBANK];
    logic [RASW-1:0]      ras_cnt  [NBANK];
    logic [CCDW-1:0]      ccd_cnt;
    logic [WW-1:0]        wait_cnt;

    logic                 accept;
    logic                 hit;
    logic                 ras_ok;
    logic                 ccd_ok;
    logic                 wait_done;
    logic                 issue_pre;
    logic                 issue_act;
    logic                 issue_col;
    logic [ADDRWIDTH-1:0] col_ext;

    assign accept    = req_valid && req_ready && (state == S_IDLE);
    assign hit       = bank_open[r_bank] && (bank_row[r_bank] == r_row);
    // Commands are registered, so a command decided now is on the pins
    // next cycle; a counter value of 1 therefore already means "expired".
    assign ras_ok    = ras_cnt[r_bank] <= RASW'(1);
    assign ccd_ok    = ccd_cnt <= CCDW'(1);
    assign wait_done = (wait_cnt == '0);
    assign col_ext   = {{(ADDRWIDTH-COLWIDTH){1'b0}}, r_col};

    // DECIDE already issues the first command so it lands two cycles after accept.
    always_comb begin
        state_n   = state;
        issue_pre = 1'b0;
        issue_act = 1'b0;
        issue_col = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) state_n = S_DECIDE;
            end
            S_DECIDE: begin
                if (hit) begin
                    if (ccd_ok) begin
                        issue_col = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        state_n   = S_COL;
                    end
                end else if (!bank_open[r_bank]) begin
                    issue_act = 1'b1;
                    state_n   = S_WAIT_RCD;
                end else if (ras_ok) begin
                    issue_pre = 1'b1;
                    state_n   = S_WAIT_RP;
                end else begin
                    state_n   = S_PRE;
                end
            end
            S_PRE: begin
                if (ras_ok) begin
                    issue_pre = 1'b1;
                    state_n   = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (wait_done) begin
                    issue_act = 1'b1;
                    state_n   = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (wait_done) begin
                    if (ccd_ok) begin
                        issue_col = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        state_n   = S_COL;
                    end
                end
            end
            S_COL: begin
                if (ccd_ok) begin
                    issue_col = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM, request latch and ready handshake.
    // Ready comes back one cycle after the column command (state is IDLE
    // with ready still low during the command cycle itself).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            r_we      <= 1'b0;
            r_bank    <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                req_ready <= 1'b0;
                r_we      <= req_we;
                r_bank    <= {req_bg, req_ba};
                r_row     <= req_row;
                r_col     <= req_col;
            end else if (state == S_IDLE) begin
                req_ready <= 1'b1;
            end
        end
    end

    // Bank table and timing counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_open <= '0;
            ccd_cnt   <= '0;
            wait_cnt  <= '0;
            for (int i = 0; i < NBANK; i++) begin
                bank_row[i] <= '0;
                ras_cnt[i]  <= '0;
            end
        end else begin
            if (issue_pre) begin
                bank_open[r_bank] <= 1'b0;
            end else if (issue_act) begin
                bank_open[r_bank] <= 1'b1;
                bank_row[r_bank]  <= r_row;
            end

            for (int i = 0; i < NBANK; i++) begin
                if (issue_act && (r_bank == BKW'(i)))
                    ras_cnt[i] <= RASW'(TRAS);
                else if (ras_cnt[i] != '0)
                    ras_cnt[i] <= ras_cnt[i] - RASW'(1);
            end

            if (issue_col)
                ccd_cnt <= CCDW'(TCCD);
            else if (ccd_cnt != '0)
                ccd_cnt <= ccd_cnt - CCDW'(1);

            // Loaded with T-1: the follow-up command is decided on the
            // cycle the counter reaches zero and appears one cycle later.
            if (issue_pre)
                wait_cnt <= WW'(TRP - 1);
            else if (issue_act)
                wait_cnt <= WW'(TRCD - 1);
            else if (wait_cnt != '0)
                wait_cnt <= wait_cnt - WW'(1);
        end
    end

    // Registered command/address pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n    <= 1'b1;
            act_n   <= 1'b1;
            A       <= '0;
            bg      <= '0;
            ba      <= '0;
            done    <= 1'b0;
            done_we <= 1'b0;
        end else begin
            cs_n    <= 1'b1;
            act_n   <= 1'b1;
            A       <= '0;
            done    <= 1'b0;
            done_we <= 1'b0;
            if (issue_act) begin
                cs_n  <= 1'b0;
                act_n <= 1'b0;
                A     <= r_row;
            end else if (issue_pre) begin
                cs_n  <= 1'b0;
                A     <= BIT_CAS;
            end else if (issue_col) begin
                cs_n    <= 1'b0;
                A       <= r_we ? (BIT_RAS | col_ext)
                                : (BIT_RAS | BIT_WE | col_ext);
                done    <= 1'b1;
                done_we <= r_we;
            end
            if (issue_act || issue_pre || issue_col) begin
                bg <= r_bank[BKW-1:BAWIDTH];
                ba <= r_bank[BAWIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// tb_ddr4_cmd_scheduler: directed stimulus, per-cycle compare against a
// timing-rule model of the scheduler, plus hand-computed literal checks.
module tb_ddr4_cmd_scheduler;

    localparam int TRP  = 4;
    localparam int TRCD = 4;
    localparam int TRAS = 10;
    localparam int TCCD = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        done;
    logic        done_we;
    logic        cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;

    ddr4_cmd_scheduler #(
        .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
        .TRP(TRP), .TRCD(TRCD), .TRAS(TRAS), .TCCD(TCCD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .done(done), .done_we(done_we),
        .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int last_done = -100;
    int prev_done = -100;
    always @(posedge clk) begin
        if (done) begin
            prev_done <= last_done;
            last_done <= cyc;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model: bank table, last ACT per bank, last column command time.
    bit m_open [16];
    int m_row  [16];
    int m_act  [16];
    int m_lastcol;
    int m_last_bk;
    int rlo;
    int rhi;
    // Expected command per cycle: kind 1=ACT 2=PRE 3=RD 4=WR
    int exp_kind [int];
    int exp_a    [int];
    int exp_bk   [int];

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
            m_act[i]  = -1000;
        end
        m_lastcol = -1000;
        m_last_bk = 0;
        rlo = 0;
        rhi = -1;
        exp_kind.delete();
        exp_a.delete();
        exp_bk.delete();
    endfunction

    function void put(input int t, input int k, input int bk, input int av);
        exp_kind[t] = k;
        exp_a[t]    = av;
        exp_bk[t]   = bk;
    endfunction

    function void model_accept(input int a, input bit we, input int bk,
                               input int row, input int col);
        int t;
        int pre;
        int act;
        int cl;
        t = a + 2;
        if (m_open[bk] && m_row[bk] == row) begin
            cl = imax(t, m_lastcol + TCCD);
        end else begin
            if (m_open[bk]) begin
                pre = imax(t, m_act[bk] + TRAS);
                put(pre, 2, bk, 'h08000);
                act = pre + TRP;
            end else begin
                act = t;
            end
            put(act, 1, bk, row);
            m_act[bk]  = act;
            m_open[bk] = 1'b1;
            m_row[bk]  = row;
            cl = imax(act + TRCD, m_lastcol + TCCD);
        end
        put(cl, we ? 4 : 3, bk, (we ? 'h10000 : 'h14000) | col);
        m_lastcol = cl;
        rlo = a + 1;
        rhi = cl;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, want);
    endtask

    // Per-cycle compare of every output against the model.
    int          k;
    logic [25:0] e_v;
    logic [25:0] g_v;
    logic [16:0] e_a;
    initial forever begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            k = exp_kind.exists(cyc) ? exp_kind[cyc] : 0;
            if (k != 0) m_last_bk = exp_bk[cyc];
            e_a = (k == 0) ? 17'h0 : 17'(exp_a[cyc]);
            e_v = {!(cyc >= rlo && cyc <= rhi), (k >= 3), (k == 4),
                   (k == 0), (k != 1), e_a, 4'(m_last_bk)};
            g_v = {req_ready, done, done_we, cs_n, act_n, A, bg, ba};
            n_chk++;
            if (g_v === e_v) n_pass++;
            else $display("FAIL cycle%0d pins: got rdy/done/we/cs/act=%b A=%h bgba=%h, expected %b A=%h bgba=%h",
                          cyc, g_v[25:21], g_v[20:4], g_v[3:0],
                          e_v[25:21], e_v[20:4], e_v[3:0]);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_req(input bit we, input int bgv, input int bav,
                          input int row, input int col, input bit hold,
                          output int a);
        int n;
        req_we    = we;
        req_bg    = 2'(bgv);
        req_ba    = 2'(bav);
        req_row   = 17'(row);
        req_col   = 10'(col);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 0, 1);
            a = cyc;
            req_valid = 1'b0;
        end else begin
            a = cyc;
            model_accept(a, we, bgv * 4 + bav, row, col);
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int b;
        int c;
        int d;
        int e;
        int x;
        int r;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_cs_act", {cs_n, act_n}, 2'b11);
        chk("rst_A_bank", {A, bg, ba}, 21'h0);
        chk("rst_done", {done, done_we}, 2'b00);
        reset_n = 1'b1;
        model_clear();
        chk_en = 1'b1;
        @(negedge clk);

        // Read to closed bank
        do_req(0, 1, 2, 'h155, 'h3A, 0, a);
        at_cyc(a + 2);
        chk("t1_act", {act_n, A}, {1'b0, 17'h155});
        chk("t1_bank", {bg, ba}, 4'h6);
        at_cyc(a + 6);
        chk("t1_rd", {cs_n, A}, {1'b0, 17'h1403A});
        chk("t1_done", {done, done_we}, 2'b10);
        idle(5);

        // Write hit to the same row
        do_req(1, 1, 2, 'h155, 'h005, 0, b);
        at_cyc(b + 2);
        chk("t2_wr", {act_n, A}, {1'b1, 17'h10005});
        chk("t2_done", {done, done_we}, 2'b11);
        idle(6);

        // Row miss straight after ACT on bank 3
        do_req(0, 0, 3, 'h111, 'h1, 0, c);
        do_req(0, 0, 3, 'h2AA, 'h2, 0, d);
        chk("t3_accept", d, c + 7);
        at_cyc(c + 11);
        chk("t3_pre_wait", cs_n, 1);
        at_cyc(c + 12);
        chk("t3_pre", {cs_n, act_n, A}, {2'b01, 17'h08000});
        at_cyc(c + 16);
        chk("t3_act", {act_n, A}, {1'b0, 17'h2AA});
        at_cyc(c + 20);
        chk("t3_rd", {done, A}, {1'b1, 17'h14002});
        idle(6);

        // Back-to-back hits on the now-open row 0x2AA
        do_req(1, 0, 3, 'h2AA, 'h7, 1, e);
        do_req(0, 0, 3, 'h2AA, 'h8, 0, x);
        chk("t4_accept2", x, e + 3);
        at_cyc(e + 6);
        chk("t4_gap", done, 0);
        at_cyc(e + 7);
        chk("t4_second", {done, A}, {1'b1, 17'h14008});
        at_cyc(e + 8);
        chk("t4_spacing", last_done - prev_done, 5);
        idle(3);

        // Banks 0 and 15 interleaved
        do_req(0, 0, 0, 'h10, 'h11, 0, a);
        at_cyc(a + 2);
        chk("t5_act0", {act_n, A, bg, ba}, {1'b0, 17'h10, 4'h0});
        do_req(0, 3, 3, 'h20, 'h21, 0, b);
        at_cyc(b + 2);
        chk("t5_act15", {act_n, A, bg, ba}, {1'b0, 17'h20, 4'hF});
        idle(8);
        do_req(0, 0, 0, 'h10, 'h12, 0, c);
        at_cyc(c + 2);
        chk("t5_hit0", {cs_n, act_n, A, bg, ba}, {2'b01, 17'h14012, 4'h0});
        idle(6);

        // Reset during WAIT_RCD
        do_req(0, 2, 1, 'h77, 'h3, 0, r);
        at_cyc(r + 3);
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t6_cs_n", cs_n, 1);
        chk("t6_ready", req_ready, 1);
        chk("t6_done", done, 0);
        chk("t6_A", A, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        chk_en = 1'b1;
        @(negedge clk);
        do_req(0, 2, 1, 'h77, 'h3, 0, r);
        at_cyc(r + 2);
        chk("t6_act_again", {act_n, A}, {1'b0, 17'h77});
        at_cyc(r + 6);
        chk("t6_rd", {done, A}, {1'b1, 17'h14003});
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
